// File: rtl/rvm_axi4_sram_slave_if.sv
// AXI4 single-beat slave bus bundle (AR/R/AW/W/B channels).
// master drives requests and ready for R/B; slave drives responses and ready for AR/AW/W.
interface rvm_axi4_sram_slave_if;
   logic [31:0] S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARSIZE;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic [31:0] S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWSIZE;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;

   modport master (
      output S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY,
      output S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY
   );

   modport slave (
      input  S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY,
      input  S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY
   );
endinterface

// File: rtl/rvm_axi4_sram_slave.sv
// AXI4 single-beat SRAM slave: one transaction in flight, WAIT_CYCLES response delay,
// SLVERR on range/alignment/size errors.
// Ports: ACLK, ARESETn (async active-low), s_axi (slave modport of rvm_axi4_sram_slave_if).
module rvm_axi4_sram_slave #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input logic                  ACLK,
   input logic                  ARESETn,
   rvm_axi4_sram_slave_if.slave s_axi
);

   localparam int unsigned AW =
      (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] LIMIT =
      {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);
   localparam logic [2:0] SIZE_W = 3'b010;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      WR_COLLECT,
      RD_WAIT,
      WR_WAIT,
      RD_RESP,
      WR_RESP
   } state_t;

   state_t        state;
   logic          en;
   logic [3:0]    cnt;
   logic          aw_got;
   logic          w_got;
   logic [AW-1:0] rd_idx;
   logic          rd_err;
   logic [AW-1:0] wr_idx;
   logic          wr_err;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;
   logic          rvalid;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          bvalid;
   logic [1:0]    bresp;

   logic [31:0]   mem [DEPTH_WORDS];

   function automatic logic addr_err(
      input logic [31:0] a,
      input logic [2:0]  sz
   );
      addr_err = (a < BASE_ADDR)
              || ({1'b0, a} >= LIMIT)
              || (a[1:0] != 2'b00)
              || (sz != SIZE_W);
   endfunction

   function automatic logic [AW-1:0] addr_idx(
      input logic [31:0] a
   );
      addr_idx = AW'((a - BASE_ADDR) >> 2);
   endfunction

   // Reads wait while any write channel is presenting, so writes win.
   logic ar_rdy;
   logic wr_open;
   logic aw_rdy;
   logic w_rdy;
   logic ar_hs;
   logic aw_hs;
   logic w_hs;
   logic aw_have;
   logic w_have;
   logic mem_we;

   assign ar_rdy  = en && (state == IDLE)
                 && !s_axi.S_AXI_AWVALID
                 && !s_axi.S_AXI_WVALID;
   assign wr_open = en && ((state == IDLE) || (state == WR_COLLECT));
   assign aw_rdy  = wr_open && !aw_got;
   assign w_rdy   = wr_open && !w_got;

   assign ar_hs   = ar_rdy && s_axi.S_AXI_ARVALID;
   assign aw_hs   = aw_rdy && s_axi.S_AXI_AWVALID;
   assign w_hs    = w_rdy && s_axi.S_AXI_WVALID;
   assign aw_have = aw_got || aw_hs;
   assign w_have  = w_got || w_hs;

   // Commit on the edge that raises BVALID.
   assign mem_we  = (state == WR_RESP) && !bvalid && !wr_err;

   assign s_axi.S_AXI_ARREADY = ar_rdy;
   assign s_axi.S_AXI_AWREADY = aw_rdy;
   assign s_axi.S_AXI_WREADY  = w_rdy;
   assign s_axi.S_AXI_RVALID  = rvalid;
   assign s_axi.S_AXI_RDATA   = rdata;
   assign s_axi.S_AXI_RRESP   = rresp;
   assign s_axi.S_AXI_BVALID  = bvalid;
   assign s_axi.S_AXI_BRESP   = bresp;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state   <= IDLE;
         en      <= 1'b0;
         cnt     <= 4'd0;
         aw_got  <= 1'b0;
         w_got   <= 1'b0;
         rd_idx  <= '0;
         rd_err  <= 1'b0;
         wr_idx  <= '0;
         wr_err  <= 1'b0;
         wdata_q <= 32'd0;
         wstrb_q <= 4'd0;
         rvalid  <= 1'b0;
         rdata   <= 32'd0;
         rresp   <= OKAY;
         bvalid  <= 1'b0;
         bresp   <= OKAY;
      end else begin
         en <= 1'b1;
         unique case (state)
            IDLE, WR_COLLECT: begin
               if (ar_hs) begin
                  rd_idx <= addr_idx(s_axi.S_AXI_ARADDR);
                  rd_err <= addr_err(s_axi.S_AXI_ARADDR,
                                     s_axi.S_AXI_ARSIZE);
                  cnt    <= WAIT_L;
                  state  <= (WAIT_L == 4'd0) ? RD_RESP : RD_WAIT;
               end
               if (aw_hs) begin
                  wr_idx <= addr_idx(s_axi.S_AXI_AWADDR);
                  wr_err <= addr_err(s_axi.S_AXI_AWADDR,
                                     s_axi.S_AXI_AWSIZE);
               end
               if (w_hs) begin
                  wdata_q <= s_axi.S_AXI_WDATA;
                  wstrb_q <= s_axi.S_AXI_WSTRB;
               end
               if (aw_have && w_have) begin
                  aw_got <= 1'b0;
                  w_got  <= 1'b0;
                  cnt    <= WAIT_L;
                  state  <= (WAIT_L == 4'd0) ? WR_RESP : WR_WAIT;
               end else if (aw_hs || w_hs) begin
                  aw_got <= aw_have;
                  w_got  <= w_have;
                  state  <= WR_COLLECT;
               end
            end
            RD_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1) state <= RD_RESP;
            end
            WR_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1) state <= WR_RESP;
            end
            RD_RESP: begin
               if (!rvalid) begin
                  rvalid <= 1'b1;
                  rresp  <= rd_err ? SLVERR : OKAY;
                  rdata  <= rd_err ? 32'd0 : mem[rd_idx];
               end else if (s_axi.S_AXI_RREADY) begin
                  rvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            WR_RESP: begin
               if (!bvalid) begin
                  bvalid <= 1'b1;
                  bresp  <= wr_err ? SLVERR : OKAY;
               end else if (s_axi.S_AXI_BREADY) begin
                  bvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Array is not reset; only strobed bytes are merged.
   always_ff @(posedge ACLK) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) begin
               mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

endmodule
